input_debouncer: RTL and testbench



---
 rtl/input_debouncer.sv | 111 +++++++++++
 tb/tb_input_debouncer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Debouncer: synchronizes a raw asynchronous input and only lets a_o follow it
// once the synchronized level has differed from a_o for STABLE_CYCLES samples.
module input_debouncer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_raw_i,
    input  logic                enable_i,
    input  logic                glitch_clr_i,
    output logic                a_o,
    output logic                busy_o,
    output logic [GLITCH_W-1:0] glitch_count_o
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GLITCH_W-1:0]    glitch_d;
    logic                   glitch_inc;

    // Synchronizer chain runs every cycle regardless of enable_i.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Next-state: qualify a differing level, abort on a bounce or on disable.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        glitch_inc = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (enable_i && s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (enable_i && !s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT_HIGH, WAIT_LOW: begin
                cnt_d = '0;
                if (!enable_i) begin
                    state_d = (state_q == WAIT_HIGH) ? STABLE_LOW : STABLE_HIGH;
                end else if (s == a_o) begin
                    state_d    = (state_q == WAIT_HIGH) ? STABLE_LOW : STABLE_HIGH;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = (state_q == WAIT_HIGH) ? STABLE_HIGH : STABLE_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear has priority over a coincident increment; the count saturates.
    always_comb begin
        glitch_d = glitch_count_o;
        if (glitch_clr_i) begin
            glitch_d = '0;
        end else if (glitch_inc && (glitch_count_o != GLITCH_MAX)) begin
            glitch_d = glitch_count_o + GLITCH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= STABLE_LOW;
            cnt_q          <= '0;
            a_o            <= 1'b0;
            busy_o         <= 1'b0;
            glitch_count_o <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            a_o            <= (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
            busy_o         <= (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
            glitch_count_o <= glitch_d;
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: a default instance and a short (STABLE_CYCLES=4,
// GLITCH_W=2) instance share stimulus and are checked against a run-length model.
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_raw = 1'b0;
    logic       enable = 1'b1;
    logic       glitch_clr = 1'b0;
    logic       a0, busy0;
    logic [7:0] g0;
    logic       a1, busy1;
    logic [1:0] g1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    input_debouncer dut0 (
        .clk           (clk),
        .reset         (reset),
        .a_raw_i       (a_raw),
        .enable_i      (enable),
        .glitch_clr_i  (glitch_clr),
        .a_o           (a0),
        .busy_o        (busy0),
        .glitch_count_o(g0)
    );

    input_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .GLITCH_W     (2)
    ) dut1 (
        .clk           (clk),
        .reset         (reset),
        .a_raw_i       (a_raw),
        .enable_i      (enable),
        .glitch_clr_i  (glitch_clr),
        .a_o           (a1),
        .busy_o        (busy1),
        .glitch_count_o(g1)
    );

    // Reference: count consecutive enabled differing samples of the delayed input.
    typedef struct packed {
        logic a;
        int   run;
        int   g;
    } mdl_t;

    mdl_t       m0, m1;
    logic [1:0] pipe;

    function automatic mdl_t mdl_next(mdl_t m, logic s, logic en, logic clr, int sc, int gmax);
        mdl_t n;
        n = m;
        if (!en) begin
            n.run = 0;
        end else if (s != m.a) begin
            n.run = m.run + 1;
            if (n.run == sc) begin
                n.a   = ~m.a;
                n.run = 0;
            end
        end else begin
            if (m.run > 0 && m.g < gmax) n.g = m.g + 1;
            n.run = 0;
        end
        if (clr) n.g = 0;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0   <= '0;
            m1   <= '0;
            pipe <= '0;
        end else begin
            m0   <= mdl_next(m0, pipe[1], enable, glitch_clr, 16, 255);
            m1   <= mdl_next(m1, pipe[1], enable, glitch_clr, 4, 3);
            pipe <= {pipe[0], a_raw};
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input logic level, input int n);
        a_raw = level;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({a0, busy0, g0, a1, busy1, g1} !== 13'd0) begin
            bad++;
            $display("FAIL reset_initial got a/busy/g=%0b/%0b/%0d %0b/%0b/%0d want all 0", a0, busy0, g0, a1, busy1, g1);
        end
        @(negedge clk);
        reset = 1'b0;
        a_raw = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({a0, busy0, g0, a1, busy1, g1} !== 13'd0) begin
            bad++;
            $display("FAIL reset_async got a/busy/g=%0b/%0b/%0d %0b/%0b/%0d want all 0", a0, busy0, g0, a1, busy1, g1);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            tick();
            total++;
            if (a1 !== 1'(k >= 5) || busy1 !== 1'(k >= 2 && k <= 4)) begin
                bad++;
                $display("FAIL reset_latency1 edge=%0d got a=%0b busy=%0b want a=%0b busy=%0b", k, a1, busy1, k >= 5, k >= 2 && k <= 4);
            end
            total++;
            if (a0 !== 1'(k >= 17)) begin
                bad++;
                $display("FAIL reset_latency0 edge=%0d got a=%0b want %0b", k, a0, k >= 17);
            end
            total++;
            if (a0 !== m0.a || busy0 !== (m0.run != 0) || g0 !== 8'(m0.g)) begin
                bad++;
                $display("FAIL reset_model0 edge=%0d got %0b/%0b/%0d want %0b/%0b/%0d", k, a0, busy0, g0, m0.a, m0.run != 0, m0.g);
            end
        end
    endtask

    task automatic test_bounce();
        int gb;
        settle(1'b0, 25);
        gb = m0.g;
        for (int b = 0; b < 8; b++) begin
            a_raw = (b % 4) < 2;
            tick();
            total++;
            if (a0 !== 1'b0 || a1 !== m1.a || g1 !== 2'(m1.g) || g0 !== 8'(m0.g)) begin
                bad++;
                $display("FAIL bounce_hold step=%0d got a0=%0b a1=%0b g0=%0d g1=%0d want 0/%0b/%0d/%0d", b, a0, a1, g0, g1, m1.a, m0.g, m1.g);
            end
        end
        a_raw = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            total++;
            if (a0 !== 1'(k >= 17) || busy0 !== (m0.run != 0) || g0 !== 8'(m0.g)) begin
                bad++;
                $display("FAIL bounce_settle edge=%0d got a=%0b busy=%0b g=%0d want a=%0b busy=%0b g=%0d", k, a0, busy0, g0, k >= 17, m0.run != 0, m0.g);
            end
        end
        total++;
        if (32'(g0) < gb + 1) begin
            bad++;
            $display("FAIL bounce_glitches got %0d want >= %0d", g0, gb + 1);
        end
    endtask

    task automatic test_falling();
        int   gb;
        int   trans;
        logic prev;
        gb    = m0.g;
        trans = 0;
        prev  = a0;
        a_raw = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            tick();
            if (a0 !== prev) trans++;
            prev = a0;
            total++;
            if (a0 !== 1'(k < 17) || g0 !== 8'(gb)) begin
                bad++;
                $display("FAIL falling edge=%0d got a=%0b g=%0d want a=%0b g=%0d", k, a0, g0, k < 17, gb);
            end
            total++;
            if (a1 !== m1.a || busy1 !== (m1.run != 0) || g1 !== 2'(m1.g)) begin
                bad++;
                $display("FAIL falling_model1 edge=%0d got %0b/%0b/%0d want %0b/%0b/%0d", k, a1, busy1, g1, m1.a, m1.run != 0, m1.g);
            end
        end
        total++;
        if (trans != 1) begin
            bad++;
            $display("FAIL falling_transitions got %0d want 1", trans);
        end
    endtask

    task automatic test_enable();
        int gb0, gb1;
        settle(1'b0, 25);
        gb0 = m0.g;
        gb1 = m1.g;
        for (int k = 0; k <= 32; k++) begin
            if (k == 0) a_raw = 1'b1;
            enable = !(k >= 4 && k <= 13);
            tick();
            total++;
            if (a0 !== 1'(k >= 29) || a1 !== 1'(k >= 17) || g0 !== 8'(gb0) || g1 !== 2'(gb1)) begin
                bad++;
                $display("FAIL enable edge=%0d got a0=%0b a1=%0b g0=%0d g1=%0d want %0b/%0b/%0d/%0d", k, a0, a1, g0, g1, k >= 29, k >= 17, gb0, gb1);
            end
            total++;
            if (busy0 !== (m0.run != 0) || busy1 !== (m1.run != 0)) begin
                bad++;
                $display("FAIL enable_busy edge=%0d got %0b/%0b want %0b/%0b", k, busy0, busy1, m0.run != 0, m1.run != 0);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_glitch_sat();
        int exp0, exp1;
        settle(1'b0, 25);
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        total++;
        if (g0 !== 8'd0 || g1 !== 2'd0) begin
            bad++;
            $display("FAIL glitch_clear got %0d/%0d want 0/0", g0, g1);
        end
        for (int p = 1; p <= 6; p++) begin
            a_raw = 1'b1;
            tick();
            a_raw = 1'b0;
            tick();
            tick();
            total++;
            if (busy1 !== 1'b1 || busy0 !== 1'b1) begin
                bad++;
                $display("FAIL glitch_busy pulse=%0d got %0b/%0b want 1/1", p, busy0, busy1);
            end
            if (p == 6) glitch_clr = 1'b1;
            tick();
            glitch_clr = 1'b0;
            exp1 = (p == 6) ? 0 : ((p > 3) ? 3 : p);
            exp0 = (p == 6) ? 0 : p;
            total++;
            if (g1 !== 2'(exp1) || g0 !== 8'(exp0)) begin
                bad++;
                $display("FAIL glitch_count pulse=%0d got %0d/%0d want %0d/%0d", p, g0, g1, exp0, exp1);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_reset_mid();
        settle(1'b0, 25);
        a_raw = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (busy0 !== 1'b1) begin
            bad++;
            $display("FAIL resetmid_busy got %0b want 1", busy0);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({a0, busy0, g0, a1, busy1, g1} !== 13'd0) begin
            bad++;
            $display("FAIL resetmid_async got %0b/%0b/%0d %0b/%0b/%0d want all 0", a0, busy0, g0, a1, busy1, g1);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            tick();
            total++;
            if (a0 !== 1'(k >= 17) || a1 !== 1'(k >= 5) || g0 !== 8'd0 || g1 !== 2'd0) begin
                bad++;
                $display("FAIL resetmid_latency edge=%0d got a0=%0b a1=%0b g0=%0d g1=%0d want %0b/%0b/0/0", k, a0, a1, g0, g1, k >= 17, k >= 5);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        int n;
        n = 0;
        while (n < 600) begin
            a_raw = 1'($urandom_range(0, 1));
            hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(3, 24));
            for (int h = 0; h < hold; h++) begin
                enable     = ($urandom_range(0, 15) != 0);
                glitch_clr = ($urandom_range(0, 63) == 0);
                tick();
                n++;
                total++;
                if (a0 !== m0.a || busy0 !== (m0.run != 0) || g0 !== 8'(m0.g)) begin
                    bad++;
                    $display("FAIL random_model0 cyc=%0d got %0b/%0b/%0d want %0b/%0b/%0d", n, a0, busy0, g0, m0.a, m0.run != 0, m0.g);
                end
                total++;
                if (a1 !== m1.a || busy1 !== (m1.run != 0) || g1 !== 2'(m1.g)) begin
                    bad++;
                    $display("FAIL random_model1 cyc=%0d got %0b/%0b/%0d want %0b/%0b/%0d", n, a1, busy1, g1, m1.a, m1.run != 0, m1.g);
                end
            end
        end
        enable     = 1'b1;
        glitch_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_falling();
        test_enable();
        test_glitch_sat();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
